// File: rtl/mips_ctrl_defs.sv
// mips_ctrl_defs: shared opcodes, datapath select encodings, state encoding and control bundle
package mips_ctrl_defs;
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LW    = 4'b0010;
  localparam logic [3:0] OP_SW    = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_JMP   = 4'b0101;
  localparam logic [3:0] OP_HALT  = 4'b1111;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_SEXT  = 2'b10;
  localparam logic [1:0] SRCB_SHIFT = 2'b11;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_WB_R   = 4'd3,
    S_ADDR   = 4'd4,
    S_WB_I   = 4'd5,
    S_MEM_RD = 4'd6,
    S_WB_MEM = 4'd7,
    S_MEM_WR = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_HALT   = 4'd11
  } state_t;
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluopt;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_t;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts stalled memory cycles within one state and flags when the wait limit is hit
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_busy,
  input  logic i_ready,
  output logic o_expired
);
  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] LIM = CW'(MEM_TIMEOUT - 1);
  logic [CW-1:0] r_cnt;
  // restart on every state change, otherwise count cycles the access is still pending
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_start) r_cnt <= '0;
    else if (i_busy && !i_ready && MEM_TIMEOUT != 0) r_cnt <= r_cnt + 1'b1;
  // a ready arriving on the limit cycle completes the access instead of expiring
  assign o_expired = (MEM_TIMEOUT != 0) && i_busy && !i_ready && (r_cnt == LIM);
endmodule

// File: rtl/multicycle_main_control.sv
// multicycle_main_control: multi-cycle main control FSM sharing one ALU and one memory port per instruction
import mips_ctrl_defs::*;
module multicycle_main_control #(
  parameter int OPC_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       ALUopt,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             halted,
  output logic             fault
);
  state_t r_state, w_next;
  ctrl_t  w_ctrl, w_out;
  logic   r_halted, r_fault, w_illegal, w_expired, w_busy, w_unused;
  function automatic logic is_op(input logic [OPC_W-1:0] o, input logic [3:0] c);
    return o == OPC_W'(c);
  endfunction
  // zero only qualifies the PC load inside the datapath
  assign w_unused = zero;
  assign w_busy = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_next != r_state),
    .i_busy    (w_busy),
    .i_ready   (mem_ready),
    .o_expired (w_expired)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_FETCH;
    else r_state <= w_next;
  // sticky status: halted on any entry to HALT, fault on illegal opcode or memory timeout
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_halted <= r_halted | (w_next == S_HALT);
      r_fault  <= r_fault | w_illegal | w_expired;
    end
  // next-state and Moore output decode, with mem_ready gating the fetch completion strobes
  always_comb begin
    w_ctrl = '0;
    w_next = r_state;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_req = 1'b1;
        w_ctrl.alu_src_b = SRCB_ONE;
        w_ctrl.aluopt = ALU_ADD;
        if (mem_ready) begin
          w_ctrl.ir_write = 1'b1;
          w_ctrl.pc_write = 1'b1;
          w_ctrl.pc_src = PC_ALU;
          w_next = S_DECODE;
        end else if (w_expired) w_next = S_HALT;
      end
      S_DECODE: begin
        w_ctrl.alu_src_b = SRCB_SHIFT;
        w_next = is_op(opcode, OP_RTYPE) ? S_EXEC_R :
                 (is_op(opcode, OP_ADDI) || is_op(opcode, OP_LW) || is_op(opcode, OP_SW)) ? S_ADDR :
                 is_op(opcode, OP_BEQ) ? S_BRANCH :
                 is_op(opcode, OP_JMP) ? S_JUMP : S_HALT;
        w_illegal = (w_next == S_HALT) && !is_op(opcode, OP_HALT);
      end
      S_EXEC_R: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_REG;
        w_ctrl.aluopt = ALU_FUNCT;
        w_next = S_WB_R;
      end
      S_WB_R: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst = 1'b1;
        w_next = S_FETCH;
      end
      S_ADDR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_SEXT;
        w_next = is_op(opcode, OP_LW) ? S_MEM_RD : is_op(opcode, OP_SW) ? S_MEM_WR : S_WB_I;
      end
      S_WB_I: begin
        w_ctrl.reg_write = 1'b1;
        w_next = S_FETCH;
      end
      S_MEM_RD: begin
        w_ctrl.mem_req = 1'b1;
        w_ctrl.iord = 1'b1;
        w_next = mem_ready ? S_WB_MEM : w_expired ? S_HALT : S_MEM_RD;
      end
      S_WB_MEM: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_next = S_FETCH;
      end
      S_MEM_WR: begin
        w_ctrl.mem_req = 1'b1;
        w_ctrl.mem_we = 1'b1;
        w_ctrl.iord = 1'b1;
        w_next = mem_ready ? S_FETCH : w_expired ? S_HALT : S_MEM_WR;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_REG;
        w_ctrl.aluopt = ALU_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_src = PC_ALUOUT;
        w_next = S_FETCH;
      end
      S_JUMP: begin
        w_ctrl.pc_write = 1'b1;
        w_ctrl.pc_src = PC_JUMP;
        w_next = S_FETCH;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end
  // every control output is forced low while reset is held, abandoning any access in flight
  assign w_out = rst_n ? w_ctrl : '0;
  assign mem_req       = w_out.mem_req;
  assign mem_we        = w_out.mem_we;
  assign iord          = w_out.iord;
  assign ir_write      = w_out.ir_write;
  assign pc_write      = w_out.pc_write;
  assign pc_write_cond = w_out.pc_write_cond;
  assign pc_src        = w_out.pc_src;
  assign alu_src_a     = w_out.alu_src_a;
  assign alu_src_b     = w_out.alu_src_b;
  assign ALUopt        = w_out.aluopt;
  assign reg_write     = w_out.reg_write;
  assign reg_dst       = w_out.reg_dst;
  assign mem_to_reg    = w_out.mem_to_reg;
  assign halted        = r_halted;
  assign fault         = r_fault;
endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control: per-cycle check of the control FSM against an instruction-level step table
module tb_multicycle_main_control;
  localparam logic [3:0] OPC_R = 4'b0000, OPC_ADDI = 4'b0001, OPC_LW = 4'b0010, OPC_SW = 4'b0011;
  localparam logic [3:0] OPC_BEQ = 4'b0100, OPC_JMP = 4'b0101, OPC_HALT = 4'b1111, OPC_BAD = 4'b1010;
  localparam logic [15:0] M_REQ = 16'h8000, M_WE = 16'h4000, M_IORD = 16'h2000, M_IR = 16'h1000;
  localparam logic [15:0] M_PW = 16'h0800, M_PWC = 16'h0400, PS_ALUOUT = 16'h0100, PS_JUMP = 16'h0200;
  localparam logic [15:0] M_A = 16'h0080, B_ONE = 16'h0020, B_SEXT = 16'h0040, B_SHIFT = 16'h0060;
  localparam logic [15:0] AO_SUB = 16'h0008, AO_FUNCT = 16'h0010, M_RW = 16'h0004, M_RD = 16'h0002, M_M2R = 16'h0001;
  localparam logic [15:0] V_IDLE = 16'h0000;
  localparam logic [15:0] V_FW   = M_REQ | B_ONE;
  localparam logic [15:0] V_FG   = M_REQ | B_ONE | M_IR | M_PW;
  localparam logic [15:0] V_DEC  = B_SHIFT;
  localparam logic [15:0] V_EXR  = M_A | AO_FUNCT;
  localparam logic [15:0] V_WBR  = M_RW | M_RD;
  localparam logic [15:0] V_ADDR = M_A | B_SEXT;
  localparam logic [15:0] V_WBI  = M_RW;
  localparam logic [15:0] V_MRD  = M_REQ | M_IORD;
  localparam logic [15:0] V_WBM  = M_RW | M_M2R;
  localparam logic [15:0] V_MWR  = M_REQ | M_WE | M_IORD;
  localparam logic [15:0] V_BR   = M_A | AO_SUB | M_PWC | PS_ALUOUT;
  localparam logic [15:0] V_JMP  = M_PW | PS_JUMP;
  logic clk, rst_n, zero, mem_ready;
  logic [3:0] opcode;
  logic mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, alu_src_a, reg_write, reg_dst, mem_to_reg, halted, fault;
  logic [1:0] pc_src, alu_src_b, ALUopt;
  logic [15:0] got, exp_ctrl;
  logic exp_on, exp_halted, exp_fault;
  int n_checks = 0, n_errors = 0;
  int n_rw = 0, n_rd = 0, n_funct = 0, n_brn = 0, n_ir = 0;
  multicycle_main_control #(.OPC_W(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ALUopt(ALUopt), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .halted(halted), .fault(fault)
  );
  assign got = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src, alu_src_a, alu_src_b, ALUopt, reg_write, reg_dst, mem_to_reg};
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask
  always @(negedge clk) if (exp_on) begin
    chk("ctrl", {16'h0, got}, {16'h0, exp_ctrl});
    chk("halted", {31'h0, halted}, {31'h0, exp_halted});
    chk("fault", {31'h0, fault}, {31'h0, exp_fault});
    chk("we_without_req", {31'h0, mem_we & ~mem_req}, 32'h0);
    chk("aluopt_unlisted", {31'h0, ALUopt == 2'b11}, 32'h0);
    if (reg_write) n_rw++;
    if (mem_req && iord) n_rd++;
    if (ALUopt == 2'b10) n_funct++;
    if (ALUopt == 2'b01 && pc_write_cond && pc_src == 2'b01) n_brn++;
    if (ir_write) n_ir++;
  end
  task automatic cyc(input logic [15:0] e, input logic rdy);
    mem_ready = rdy;
    exp_ctrl = e;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [3:0] op, input int fwait, input int mwait, input logic z);
    opcode = op;
    zero = z;
    for (int i = 0; i < fwait; i++) cyc(V_FW, 1'b0);
    cyc(V_FG, 1'b1);
    cyc(V_DEC, 1'b0);
    case (op)
      OPC_R:    begin cyc(V_EXR, 1'b0); cyc(V_WBR, 1'b0); end
      OPC_ADDI: begin cyc(V_ADDR, 1'b0); cyc(V_WBI, 1'b0); end
      OPC_LW: begin
        cyc(V_ADDR, 1'b0);
        for (int i = 0; i < mwait; i++) cyc(V_MRD, 1'b0);
        cyc(V_MRD, 1'b1);
        cyc(V_WBM, 1'b0);
      end
      OPC_SW: begin
        cyc(V_ADDR, 1'b0);
        for (int i = 0; i < mwait; i++) cyc(V_MWR, 1'b0);
        cyc(V_MWR, 1'b1);
      end
      OPC_BEQ: cyc(V_BR, 1'b0);
      OPC_JMP: cyc(V_JMP, 1'b0);
      default: ;
    endcase
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    exp_ctrl = V_IDLE;
    exp_halted = 1'b0;
    exp_fault = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    int s_rw, s_rd, s_fn, s_br, s_ir;
    rst_n = 1'b0; opcode = OPC_R; zero = 1'b0; mem_ready = 1'b1;
    exp_ctrl = V_IDLE; exp_halted = 1'b0; exp_fault = 1'b0; exp_on = 1'b1;
    #2;
    chk("reset_outputs", {16'h0, got, halted, fault}, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_rw = n_rw; s_fn = n_funct; s_ir = n_ir;
    run(OPC_R, 0, 0, 1'b0);
    chk("rtype_funct_once", n_funct - s_fn, 1);
    chk("rtype_rw_once", n_rw - s_rw, 1);
    chk("rtype_ir_once", n_ir - s_ir, 1);
    mem_ready = 1'b1;
    #1;
    chk("rtype_refetch_cycle5", {30'h0, mem_req, ir_write}, 32'h3);
    run(OPC_ADDI, 1, 0, 1'b0);
    s_rw = n_rw; s_rd = n_rd;
    run(OPC_LW, 0, 3, 1'b0);
    chk("lw_memrd_cycles", n_rd - s_rd, 4);
    chk("lw_rw_once", n_rw - s_rw, 1);
    run(OPC_SW, 0, 2, 1'b0);
    s_br = n_brn;
    run(OPC_BEQ, 0, 0, 1'b0);
    run(OPC_BEQ, 0, 0, 1'b1);
    chk("beq_branch_cycles", n_brn - s_br, 2);
    run(OPC_JMP, 2, 0, 1'b0);
    opcode = OPC_BAD;
    cyc(V_FG, 1'b1);
    cyc(V_DEC, 1'b0);
    exp_fault = 1'b1; exp_halted = 1'b1;
    for (int i = 0; i < 20; i++) cyc(V_IDLE, i[0]);
    chk("illegal_halted_held", {30'h0, halted, fault}, 32'h3);
    do_reset();
    chk("illegal_cleared", {30'h0, halted, fault}, 32'h0);
    opcode = OPC_HALT;
    cyc(V_FG, 1'b1);
    cyc(V_DEC, 1'b0);
    exp_halted = 1'b1;
    for (int i = 0; i < 5; i++) cyc(V_IDLE, 1'b1);
    chk("halt_no_fault", {30'h0, halted, fault}, 32'h2);
    do_reset();
    for (int i = 0; i < 15; i++) cyc(V_FW, 1'b0);
    exp_fault = 1'b1; exp_halted = 1'b1;
    for (int i = 0; i < 3; i++) cyc(V_IDLE, 1'b0);
    chk("fetch_timeout_fault", {31'h0, fault}, 32'h1);
    do_reset();
    run(OPC_R, 14, 0, 1'b0);
    chk("ready_on_limit_no_fault", {31'h0, fault}, 32'h0);
    opcode = OPC_LW;
    cyc(V_FG, 1'b1);
    cyc(V_DEC, 1'b0);
    cyc(V_ADDR, 1'b0);
    for (int i = 0; i < 15; i++) cyc(V_MRD, 1'b0);
    exp_fault = 1'b1; exp_halted = 1'b1;
    for (int i = 0; i < 2; i++) cyc(V_IDLE, 1'b0);
    do_reset();
    opcode = OPC_SW;
    cyc(V_FG, 1'b1);
    cyc(V_DEC, 1'b0);
    cyc(V_ADDR, 1'b0);
    cyc(V_MWR, 1'b0);
    mem_ready = 1'b0;
    exp_ctrl = V_MWR;
    #1;
    chk("memwr_active", {30'h0, mem_req, mem_we}, 32'h3);
    rst_n = 1'b0;
    #1;
    chk("memwr_async_drop", {30'h0, mem_req, mem_we}, 32'h0);
    exp_ctrl = V_IDLE;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_reset_flags", {30'h0, halted, fault}, 32'h0);
    run(OPC_R, 0, 0, 1'b0);
    exp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multi-cycle main control FSM for the MIPS-like core.
- Sequences fetch, decode, execute, memory and write-back over several cycles, so one ALU and one unified memory port are shared across an instruction.
- Drives the 2-bit ALU operation select consumed by the ALU control circuit (00 = add, 01 = subtract, 1x = take funct[1:0]), plus all datapath enables and muxes.
- Stalls on a ready/valid memory handshake.

Parameters:
- OPC_W, 4, opcode field width.
- MEM_TIMEOUT, 15, maximum cycles to wait for mem_ready before flagging a bus error; 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OPC_W  instruction opcode from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write access (valid with mem_req)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load instruction register
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_src_a  out  1  ALU A: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B: 00 = register B, 01 = constant 1, 10 = sign-extended immediate, 11 = shifted immediate
- ALUopt  out  2  to the ALU control circuit
- reg_write  out  1  register file write
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- mem_to_reg  out  1  write-back data: 0 = ALUOut, 1 = MDR
- halted  out  1  sticky; set on HALT
- fault  out  1  sticky; set on illegal opcode or memory timeout

Behaviour:
- Opcodes:
  - 0000 R-type
  - 0001 ADDI
  - 0010 LW
  - 0011 SW
  - 0100 BEQ
  - 0101 JMP
  - 1111 HALT
  - all others illegal
- Reset:
  - Asynchronous reset puts the state in FETCH.
  - halted, fault and the timeout counter clear to 0.
  - Every output is 0 while rst_n is low. Reset mid-access abandons the access with no write.
- Output timing: outputs are a Moore decode of the state. Outputs qualified "on mem_ready" are additionally gated by mem_ready in the same cycle (Mealy term).
- States and transitions:
  - FETCH:
    - Drives mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, ALUopt=00.
    - On mem_ready it also drives ir_write=1, pc_write=1, pc_src=00, then goes to DECODE.
    - Otherwise it stays in FETCH.
  - DECODE:
    - Drives alu_src_a=0, alu_src_b=11, ALUopt=00 to precompute the branch target into ALUOut.
    - Next state:
      - R-type → EXEC_R
      - ADDI, LW, SW → ADDR
      - BEQ → BRANCH
      - JMP → JUMP
      - HALT → HALT
      - illegal → set fault, go to HALT
  - EXEC_R: alu_src_a=1, alu_src_b=00, ALUopt=10 → WB_R.
  - WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
  - ADDR:
    - Drives alu_src_a=1, alu_src_b=10, ALUopt=00.
    - Next state: LW → MEM_RD; SW → MEM_WR; ADDI → WB_I.
  - WB_I: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
  - MEM_RD: mem_req=1, iord=1; waits for mem_ready → WB_MEM.
  - WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1 → FETCH.
  - MEM_WR: mem_req=1, mem_we=1, iord=1; waits for mem_ready → FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, ALUopt=01, pc_write_cond=1, pc_src=01 → FETCH. The datapath gates the PC load with zero; zero is a pass-through only.
  - JUMP: pc_write=1, pc_src=10 → FETCH.
  - HALT: sets halted, all enables 0, stays in HALT until reset.
- Memory timeout:
  - The counter resets on every state entry and increments each cycle mem_req is high without mem_ready.
  - When it reaches MEM_TIMEOUT: set fault, go to HALT, drop mem_req the next cycle.
  - mem_ready arriving in the same cycle as the limit is reached wins; there is no fault.
- Invariants:
  - mem_req, ir_write and pc_write are deasserted outside FETCH, MEM_RD, MEM_WR and JUMP as listed.
  - mem_we is never high without mem_req.
  - A state sets reg_write for exactly one cycle per instruction.
- Latency with zero memory wait: R-type 4 cycles; ADDI 4; LW 5; SW 4; BEQ 3; JMP 3.
- An unlisted ALUopt value is never driven; ALUopt is 00 in idle states.

Decomposition:
- Shared package/header `mips_ctrl_defs` holds:
  - opcode constants
  - ALUopt encodings (ALU_ADD=00, ALU_SUB=01, ALU_FUNCT=10)
  - pc_src and alu_src_b encodings
  - the state encoding (4-bit)
- Sub-module `mem_wait_timer`: the timeout counter with start/ready inputs and an expired output.
- The FSM next-state logic and output decode stay in the top module.

Test Plan:
- R-type, mem_ready always 1:
  - FETCH asserts ir_write, pc_write; DECODE; EXEC_R with ALUopt=10.
  - WB_R with reg_write=1, reg_dst=1.
  - Back in FETCH on cycle 5.
- LW with mem_ready low for 3 cycles in MEM_RD:
  - mem_req held with iord=1 for 4 cycles.
  - WB_MEM asserts mem_to_reg=1, reg_write=1 exactly once.
- BEQ:
  - BRANCH state drives ALUopt=01, pc_write_cond=1, pc_src=01.
  - Total 3 cycles regardless of zero.
- Opcode 1010:
  - fault=1 after DECODE; HALT reached; all enables 0 for 20 cycles.
  - halted=1 held until rst_n low.
- MEM_TIMEOUT=15, mem_ready stuck at 0 in FETCH:
  - fault rises after 15 cycles, then HALT.
  - Repeat with mem_ready=1 on cycle 15: no fault, DECODE entered.
- rst_n pulsed low during MEM_WR:
  - mem_req and mem_we drop to 0 asynchronously.
  - After release, first state is FETCH, halted=0, fault=0.
